// File: rtl/bcast_unit_pkg.sv
// Shared definitions for the broadcast fan-out unit: flit field layout,
// algorithmic opcodes, FSM state encoding and small flit helpers.
package bcast_unit_pkg;

  // Flit layout, built up from the payload at bit 0 to the valid bit on top.
  localparam int PayloadWidth = 32;
  localparam int OpWidth      = 4;
  localparam int AlgWidth     = 4;
  localparam int TagWidth     = 6;
  localparam int CtxWidth     = 8;
  localparam int RankWidth    = 9;
  localparam int CoordWidth   = 9;

  localparam int OpPos       = PayloadWidth;
  localparam int AlgPos      = OpPos + OpWidth;
  localparam int TagPos      = AlgPos + AlgWidth;
  localparam int ContextPos  = TagPos + TagWidth;
  localparam int RankPos     = ContextPos + CtxWidth;
  localparam int SrcPos      = RankPos + RankWidth;
  localparam int DstPos      = SrcPos + CoordWidth;
  localparam int ValidBitPos = DstPos + CoordWidth;
  localparam int FlitWidth   = ValidBitPos + 1;

  // Width of the binomial-tree level counter (levels 0..8).
  localparam int KWidth = 4;

  localparam logic [OpWidth-1:0] OpLargeBcast  = 4'b0101;
  localparam logic [OpWidth-1:0] OpMediumBcast = 4'b0110;
  localparam logic [OpWidth-1:0] OpShortBcast  = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LOCAL = 2'd2,
    ST_PASS  = 2'd3
  } state_t;

  function automatic logic is_bcast(input logic [FlitWidth-1:0] flit);
    logic [OpWidth-1:0] op;
    op = flit[OpPos +: OpWidth];
    return (op == OpLargeBcast) || (op == OpMediumBcast) || (op == OpShortBcast);
  endfunction

  function automatic logic [FlitWidth-1:0] with_dst(input logic [FlitWidth-1:0] flit,
                                                    input logic [CoordWidth-1:0] dst);
    logic [FlitWidth-1:0] f;
    f = flit;
    f[DstPos +: CoordWidth] = dst;
    return f;
  endfunction

endpackage

// File: rtl/bcast_child_gen.sv
// Binomial-tree child generator. For a node relative to a broadcast root it
// reports the child at tree level k, the first (highest) level to emit, the
// last level (bit-length of own^root) and whether any children exist at all.
module bcast_child_gen
  import bcast_unit_pkg::*;
#(
  parameter int lg_numprocs = 3
) (
  input  logic [CoordWidth-1:0] own_id,
  input  logic [CoordWidth-1:0] root_id,
  input  logic [KWidth-1:0]     k,
  output logic [CoordWidth-1:0] child_id,
  output logic [KWidth-1:0]     first_k,
  output logic [KWidth-1:0]     last_k,
  output logic                  has_children
);

  localparam logic [CoordWidth-1:0] IdMask = CoordWidth'((1 << lg_numprocs) - 1);

  logic [CoordWidth-1:0] rel;
  logic [CoordWidth-1:0] step;

  assign rel = (own_id ^ root_id) & IdMask;

  // Bit-length of the relative id; levels below it belong to other subtrees.
  always_comb begin
    last_k = '0;
    for (int i = 0; i < CoordWidth; i++) begin
      if (rel[i]) last_k = KWidth'(i + 1);
    end
  end

  assign step         = CoordWidth'(1) << k;
  assign child_id     = ((rel + step) ^ root_id) & IdMask;
  assign first_k      = KWidth'(lg_numprocs - 1);
  assign has_children = (last_k < KWidth'(lg_numprocs));

endmodule

// File: rtl/bcast_unit.sv
// Broadcast fan-out unit. Pops one flit at a time from a first-word-fall-through
// FIFO and either passes it on, expands it into binomial-tree child flits, or
// hands it to the host port.
// Build option: define BCAST_LOCAL_COPY_EN to keep the host-copy (LOCAL) state;
// without it local_valid/local_packet are tied to 0 and own-destined flits that
// would need a host copy are dropped.
module bcast_unit
  import bcast_unit_pkg::*;
#(
  parameter logic [2:0] rank_z      = 3'b0,
  parameter logic [2:0] rank_y      = 3'b0,
  parameter logic [2:0] rank_x      = 3'b0,
  parameter int         lg_numprocs = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FlitWidth-1:0] in_packet,
  input  logic                 in_empty,
  output logic                 rd_en,
  output logic [FlitWidth-1:0] out_packet,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FlitWidth-1:0] local_packet,
  output logic                 local_valid,
  input  logic                 local_ready,
  output logic                 busy
);

  localparam logic [CoordWidth-1:0] OwnCoords = {rank_z, rank_y, rank_x};

  state_t                state;
  logic [FlitWidth-1:0]  flit;
  logic [KWidth-1:0]     k_q;

  logic [CoordWidth-1:0] root_sel;
  logic [KWidth-1:0]     k_sel;
  logic [CoordWidth-1:0] child_id;
  logic [KWidth-1:0]     first_k;
  logic [KWidth-1:0]     last_k;
  logic                  has_children;

  assign rd_en = !rst && (state == ST_IDLE) && !in_empty;
  assign busy  = (state != ST_IDLE);

  // In IDLE the generator looks at the FIFO head so the first child is ready
  // at pop time; in SEND it looks one level below the flit currently offered.
  assign root_sel = (state == ST_IDLE) ? in_packet[SrcPos +: CoordWidth]
                                       : flit[SrcPos +: CoordWidth];
  assign k_sel    = (state == ST_IDLE) ? first_k : (k_q - KWidth'(1));

  bcast_child_gen #(.lg_numprocs(lg_numprocs)) u_child_gen (
    .own_id       (OwnCoords),
    .root_id      (root_sel),
    .k            (k_sel),
    .child_id     (child_id),
    .first_k      (first_k),
    .last_k       (last_k),
    .has_children (has_children)
  );

`ifndef BCAST_LOCAL_COPY_EN
  logic unused_bits;
  assign unused_bits  = ^{local_ready, flit[DstPos +: CoordWidth]};
  assign local_valid  = 1'b0;
  assign local_packet = '0;
`endif

  // Control FSM with registered output flits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      flit       <= '0;
      k_q        <= '0;
      out_valid  <= 1'b0;
      out_packet <= '0;
`ifdef BCAST_LOCAL_COPY_EN
      local_valid  <= 1'b0;
      local_packet <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (!in_empty) begin
            flit <= in_packet;
            k_q  <= first_k;
            if (!in_packet[ValidBitPos]) begin
              state <= ST_IDLE;
            end else if (in_packet[DstPos +: CoordWidth] != OwnCoords) begin
              state      <= ST_PASS;
              out_valid  <= 1'b1;
              out_packet <= in_packet;
            end else if (is_bcast(in_packet) && has_children) begin
              state      <= ST_SEND;
              out_valid  <= 1'b1;
              out_packet <= with_dst(in_packet, child_id);
            end else begin
`ifdef BCAST_LOCAL_COPY_EN
              state        <= ST_LOCAL;
              local_valid  <= 1'b1;
              local_packet <= in_packet;
`else
              state <= ST_IDLE;
`endif
            end
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (k_q == last_k) begin
              out_valid  <= 1'b0;
              out_packet <= '0;
`ifdef BCAST_LOCAL_COPY_EN
              state        <= ST_LOCAL;
              local_valid  <= 1'b1;
              local_packet <= flit;
`else
              state <= ST_IDLE;
`endif
            end else begin
              k_q        <= k_q - KWidth'(1);
              out_packet <= with_dst(flit, child_id);
            end
          end
        end
`ifdef BCAST_LOCAL_COPY_EN
        ST_LOCAL: begin
          if (local_ready) begin
            local_valid  <= 1'b0;
            local_packet <= '0;
            state        <= ST_IDLE;
          end
        end
`endif
        ST_PASS: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            out_packet <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bcast_unit.md
Name: bcast_unit

Overview:
- Fan-out counterpart of the reduction unit: it expands one broadcast flit into per-child flits along a binomial tree, where the reduction unit combines many flits into one.
- Sits between the router input FIFO (first-word-fall-through) and the router output stage.
- Non-broadcast flits not addressed to this node pass through unchanged.
- Optionally delivers a local copy to the host port.

Parameters:
- rank_z, 3'b0, this node's z coordinate
- rank_y, 3'b0, this node's y coordinate
- rank_x, 3'b0, this node's x coordinate
- lg_numprocs, 3, log2 of node count (1..9)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-high
- in_packet  in  82  FIFO head flit, standard layout (valid[81], dst[80:72], src[71:63], rank, contextId, tag, algtype, op[35:32], payload[31:0])
- in_empty  in  1  FIFO empty
- rd_en  out  1  pop FIFO this cycle
- out_packet  out  82  flit to router
- out_valid  out  1  out_packet valid
- out_ready  in  1  router accepts out_packet
- local_packet  out  82  host copy
- local_valid  out  1  local_packet valid
- local_ready  in  1  host accepts
- busy  out  1  state != IDLE

Behaviour:
- Node id = low lg_numprocs bits of {z,y,x}. Child id maps back into dst with the upper bits zero.
- Reset: state IDLE; rd_en, out_valid, local_valid and busy are 0; out_packet and local_packet are 0. Reset mid-operation aborts immediately; the captured flit is discarded.
- FSM states: IDLE, SEND, LOCAL, PASS.
- IDLE, in_empty=1: stay in IDLE.
- IDLE, !in_empty: rd_en=1 for exactly that cycle (combinational from state==IDLE && !in_empty), and in_packet is captured in the same cycle. Then:
  - valid bit 0: drop and stay IDLE.
  - dst != own coords: go to PASS.
  - dst == own coords, op in {LargeBcast 0101, MediumBcast 0110, ShortBcast 0111}: go to SEND.
  - dst == own coords, any other op: go to LOCAL.
- Child computation:
  - root = src field; r = own_id XOR root_id.
  - b = bit-length of r (0 when r=0).
  - Children exist for k = lg_numprocs-1 down to b, emitted in descending k.
  - Child id = (r + 2^k) XOR root_id.
  - Child count = lg_numprocs - b. Zero children (r >= 2^(lg_numprocs-1)) skips SEND and goes straight to LOCAL.
- SEND:
  - out_valid=1.
  - out_packet = captured flit with dst replaced by the child coords; src, op, tag and payload are unchanged.
  - A flit is held stable until out_valid && out_ready.
  - The k counter decrements on each accept. After the k=b accept, go to LOCAL.
  - One flit per cycle under continuous ready.
- LOCAL: local_valid=1 and local_packet = captured flit, held until local_ready; then go to IDLE.
- PASS: out_packet = captured flit, held until accepted; then go to IDLE.
- Latency: the first SEND flit is visible the cycle after the pop. A root on 8 nodes with ready tied high needs 3 out cycles plus 1 local cycle.
- Only one flit is in flight; no new pop occurs until the FSM returns to IDLE. There is a minimum of one IDLE cycle between flits.
- out_valid and local_valid are never asserted together.

Optional Feature:
- BCAST_LOCAL_COPY_EN defined: LOCAL state exists as described above.
- BCAST_LOCAL_COPY_EN undefined:
  - LOCAL is removed: SEND returns directly to IDLE, and non-bcast own-dst flits are dropped after the pop.
  - local_valid and local_packet are tied to 0.

Decomposition:
- Shared package holds:
  - field position/width localparams (PayloadWidth, opPos, TagPos, Src/Dst pos, ValidBitPos, FlitWidth)
  - algorithmic opcode constants
  - FSM state typedef
- Sub-module bcast_child_gen (combinational): inputs own_id, root_id, k; outputs child_id, first_k, has_children.

Test Plan:
- lg=3, rank x=0. Flit dst=0, src=0, op=0111, payload 0xDEADBEEF; ready high.
  -> out dst x=4,2,1 on consecutive cycles, payload unchanged; then local_valid with payload 0xDEADBEEF; rd_en pulsed once.
- rank x=3, src x=3 (root):
  -> dst sequence 7,1,2.
- rank x=2, src=0:
  -> single flit dst=6, then local.
- rank x=5, src x=1:
  -> no out_valid; local only.
- dst x=6 at node 0, op=1111:
  -> one out flit bit-identical to input.
- out_ready low 5 cycles during the second child:
  -> out_packet stable, no skip.
- rst asserted mid-SEND:
  -> outputs 0 the same cycle; next flit processes cleanly.
- Build with BCAST_LOCAL_COPY_EN undefined:
  -> local_valid is never asserted.
